// File: rtl/rsc_tail_encoder_if.sv
// Handshake bundle for the LTE RSC constituent encoder: frame control, the input bit
// stream and the systematic/parity output stream.
interface rsc_tail_encoder_if #(
    parameter int KW = 13
);
    logic          start;
    logic [KW-1:0] frame_len;
    logic          in_bit;
    logic          in_valid;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic          out_sys;
    logic          out_par;
    logic          out_tail;
    logic          out_last;
    logic          busy;
    logic          len_err;

    modport master (
        output start, frame_len, in_bit, in_valid, out_ready,
        input  in_ready, out_valid, out_sys, out_par, out_tail, out_last, busy, len_err
    );

    modport slave (
        input  start, frame_len, in_bit, in_valid, out_ready,
        output in_ready, out_valid, out_sys, out_par, out_tail, out_last, busy, len_err
    );
endinterface

// File: rtl/rsc_tail_encoder.sv
// LTE RSC constituent encoder (g0 = 1+D^2+D^3, g1 = 1+D+D^3) with per-frame
// trellis termination; single output register stage, 1-cycle latency.
module rsc_tail_encoder #(
    parameter int K_MAX = 6144,
    parameter int KW    = 13
) (
    input  logic                i_clk,
    input  logic                i_rst,
    rsc_tail_encoder_if.slave   io_enc
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_TAIL,
        ST_DRAIN
    } state_t;

    state_t        r_state;
    logic          r_s1, r_s2, r_s3;
    logic [KW-1:0] r_len;
    logic [KW-1:0] r_cnt;
    logic [1:0]    r_tail_cnt;
    logic          r_out_valid;
    logic          r_out_sys;
    logic          r_out_par;
    logic          r_out_tail;
    logic          r_out_last;
    logic          r_busy;
    logic          r_len_err;

    logic          w_load;
    logic          w_in_hs;
    logic          w_u;
    logic          w_fb;
    logic          w_par;
    logic          w_len_ok;
    logic [KW-1:0] w_cnt_next;

    // During termination the input is chosen to cancel the feedback, driving the state to zero.
    assign w_u        = (r_state == ST_TAIL) ? (r_s2 ^ r_s3) : io_enc.in_bit;
    assign w_fb       = w_u ^ r_s2 ^ r_s3;
    assign w_par      = w_fb ^ r_s1 ^ r_s3;
    assign w_load     = !r_out_valid || io_enc.out_ready;
    assign w_in_hs    = io_enc.in_valid && io_enc.in_ready;
    assign w_len_ok   = (io_enc.frame_len != '0) && (io_enc.frame_len <= KW'(K_MAX));
    assign w_cnt_next = r_cnt + KW'(1);

    assign io_enc.in_ready  = (r_state == ST_DATA) && w_load;
    assign io_enc.out_valid = r_out_valid;
    assign io_enc.out_sys   = r_out_sys;
    assign io_enc.out_par   = r_out_par;
    assign io_enc.out_tail  = r_out_tail;
    assign io_enc.out_last  = r_out_last;
    assign io_enc.busy      = r_busy;
    assign io_enc.len_err   = r_len_err;

    // NOTE: all state uses non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_s1        <= 1'b0;
            r_s2        <= 1'b0;
            r_s3        <= 1'b0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_tail_cnt  <= 2'd0;
            r_out_valid <= 1'b0;
            r_out_sys   <= 1'b0;
            r_out_par   <= 1'b0;
            r_out_tail  <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_len_err   <= 1'b0;
        end else begin
            r_len_err <= 1'b0;
            if (w_load) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (io_enc.start) begin
                        if (w_len_ok) begin
                            r_len   <= io_enc.frame_len;
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= ST_DATA;
                        end else begin
                            r_len_err <= 1'b1;
                        end
                    end
                end

                ST_DATA: begin
                    if (w_in_hs) begin
                        r_out_valid <= 1'b1;
                        r_out_sys   <= w_u;
                        r_out_par   <= w_par;
                        r_out_tail  <= 1'b0;
                        r_out_last  <= 1'b0;
                        {r_s1, r_s2, r_s3} <= {w_fb, r_s1, r_s2};
                        r_cnt <= w_cnt_next;
                        if (w_cnt_next == r_len) begin
                            r_tail_cnt <= 2'd0;
                            r_state    <= ST_TAIL;
                        end
                    end
                end

                ST_TAIL: begin
                    if (w_load) begin
                        r_out_valid <= 1'b1;
                        r_out_sys   <= w_u;
                        r_out_par   <= w_par;
                        r_out_tail  <= 1'b1;
                        r_out_last  <= (r_tail_cnt == 2'd2);
                        {r_s1, r_s2, r_s3} <= {w_fb, r_s1, r_s2};
                        r_tail_cnt <= r_tail_cnt + 2'd1;
                        if (r_tail_cnt == 2'd2) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end

                ST_DRAIN: begin
                    if (r_out_valid && io_enc.out_ready) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rsc_tail_encoder.sv
// Directed bench for rsc_tail_encoder: hand-derived beat sequences, stalls, length
// errors, mid-frame reset and back-to-back frames.
module tb_rsc_tail_encoder;
    localparam int KW    = 13;
    localparam int K_MAX = 6144;

    logic clk;
    logic rst;

    rsc_tail_encoder_if #(.KW(KW)) bus ();

    rsc_tail_encoder #(.K_MAX(K_MAX), .KW(KW)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_enc (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int timeouts = 0;
    int cyc      = 0;
    bit stall_mode = 1'b0;

    logic bits [0:15];
    logic [3:0] got [$];            // {sys, par, tail, last} per accepted beat
    logic [3:0] exp_q [$];
    int   stab_err  = 0;
    int   rdy_err   = 0;
    int   lerr_cnt  = 0;
    logic prev_stall = 1'b0;
    logic [4:0] prev_beat = '0;

    // Beats are recorded at the negedge before the edge that accepts them.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid && bus.out_ready)
                got.push_back({bus.out_sys, bus.out_par, bus.out_tail, bus.out_last});
            if (prev_stall && (prev_beat !== {bus.out_valid, bus.out_sys, bus.out_par,
                                              bus.out_tail, bus.out_last}))
                stab_err++;
            if (bus.out_valid && !bus.out_ready && bus.in_ready)
                rdy_err++;
            if (bus.len_err)
                lerr_cnt++;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_beat  = {bus.out_valid, bus.out_sys, bus.out_par, bus.out_tail, bus.out_last};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        bus.start = 1'b0;
        case (cyc % 4)
            1, 2:    bus.out_ready = stall_mode ? 1'b0 : 1'b1;
            default: bus.out_ready = 1'b1;
        endcase
    endtask

    task automatic feed(input int n);
        for (int i = 0; i < n; i++) begin
            bit hs;
            int guard;
            bus.in_valid = 1'b1;
            bus.in_bit   = bits[i];
            hs    = 1'b0;
            guard = 0;
            while (!hs && guard < 50) begin
                @(negedge clk);
                hs = bus.in_ready;
                step();
                guard++;
            end
            if (!hs) timeouts++;
        end
        bus.in_valid = 1'b0;
        bus.in_bit   = 1'b0;
    endtask

    task automatic run_frame(input int k);
        int guard;
        bus.start     = 1'b1;
        bus.frame_len = KW'(k);
        feed(k);
        guard = 0;
        while (bus.busy && guard < 100) begin
            step();
            guard++;
        end
        if (bus.busy) timeouts++;
    endtask

    task automatic check_beats(input string tag);
        check({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check($sformatf("%s_beat%0d", tag, i + 1), 32'(got[i]), 32'(exp_q[i]));
        got.delete();
    endtask

    task automatic load_exp_a();
        exp_q = '{4'b1100, 4'b0100, 4'b0100, 4'b0100, 4'b1110, 4'b0110, 4'b1111};
    endtask

    task automatic set_bits_1000();
        bits[0] = 1'b1; bits[1] = 1'b0; bits[2] = 1'b0; bits[3] = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.frame_len = '0;
        bus.in_bit    = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) bits[i] = 1'b0;
        step();
        step();
        check("reset_outputs",
              {bus.out_valid, bus.out_sys, bus.out_par, bus.out_tail, bus.out_last,
               bus.busy, bus.len_err, bus.in_ready}, 8'h00);
        rst = 1'b0;
        step();

        // K=4, 1,0,0,0, no backpressure
        set_bits_1000();
        run_frame(4);
        load_exp_a();
        check_beats("k4");
        check("k4_final_state", {dut.r_s1, dut.r_s2, dut.r_s3}, 3'b000);
        check("k4_busy_low", bus.busy, 1'b0);

        // K=8 all zeros
        for (int i = 0; i < 8; i++) bits[i] = 1'b0;
        run_frame(8);
        exp_q = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                  4'b0010, 4'b0010, 4'b0011};
        check_beats("k8z");
        check("k8z_final_state", {dut.r_s1, dut.r_s2, dut.r_s3}, 3'b000);

        // K=4 with out_ready pattern 1,0,0,1
        stall_mode = 1'b1;
        set_bits_1000();
        run_frame(4);
        stall_mode = 1'b0;
        step();
        load_exp_a();
        check_beats("stall");
        check("stall_hold_stable", stab_err, 0);
        check("stall_in_ready_low", rdy_err, 0);
        check("stall_final_state", {dut.r_s1, dut.r_s2, dut.r_s3}, 3'b000);

        // Illegal frame lengths
        lerr_cnt = 0;
        bus.start = 1'b1; bus.frame_len = KW'(0);
        step();
        check("len0_pulse", bus.len_err, 1'b1);
        step();
        check("len0_pulse_end", bus.len_err, 1'b0);
        bus.start = 1'b1; bus.frame_len = KW'(K_MAX + 1);
        step();
        check("lenmax_pulse", bus.len_err, 1'b1);
        step();
        step();
        check("len_err_pulses", lerr_cnt, 2);
        check("len_err_busy", bus.busy, 1'b0);
        check("len_err_no_beats", got.size(), 0);

        // Reset after two data bits of a K=4 frame
        set_bits_1000();
        bus.start = 1'b1; bus.frame_len = KW'(4);
        feed(2);
        rst = 1'b1;
        step();
        check("midreset_outputs",
              {bus.out_valid, bus.out_sys, bus.out_par, bus.out_tail, bus.out_last,
               bus.busy, bus.len_err, bus.in_ready}, 8'h00);
        check("midreset_idle", {30'd0, dut.r_state}, 32'd0);
        rst = 1'b0;
        step();
        got.delete();
        run_frame(4);
        load_exp_a();
        check_beats("postreset");

        // Two back-to-back K=1 frames, bit 1 each: state after data is (1,0,0)
        bits[0] = 1'b1;
        run_frame(1);
        run_frame(1);
        exp_q = '{4'b1100, 4'b0110, 4'b1010, 4'b1111,
                  4'b1100, 4'b0110, 4'b1010, 4'b1111};
        check_beats("b2b");
        check("b2b_final_state", {dut.r_s1, dut.r_s2, dut.r_s3}, 3'b000);

        check("no_timeouts", timeouts, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
